uart_rx: RTL
============

Name: uart_rx

Overview:
Receives serial data using the UART protocol (8N1 by default) and pairs with the team's UART transmitter. It oversamples `rx` with the shared 16x baud `s_tick` and samples each bit at its midpoint. Each received character is presented on a parallel output with a one-clock done pulse and a framing-error flag. Parity is not implemented.

Parameters:
- DATA_BIT, 8, number of data bits per frame, LSB first; legal range 5..8.
- STOP_BIT, 1, number of stop bits; legal values 1 or 2. The stop sample point is STOP_BIT*16 s_ticks after the last data-bit sample.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- s_tick  input  1  one-clk pulse at 16x the baud rate; each bit lasts 16 s_ticks
- rx  input  1  serial line, idle HIGH, asynchronous to clk
- rx_done_tick  output  1  one-clk pulse when a frame completes
- rx_data  output  8  received data; valid when rx_done_tick is high and held until the next frame completes
- frame_err  output  1  stop bit was sampled LOW in the last frame; updated on each rx_done_tick

Behaviour:
- Clocking and reset:
  - Single clock `clk`, async active-low `reset_n`. All state resets asynchronously.
  - Reset values: state=idle, s_reg=0, n_reg=0, b_reg=0, rx_data=0, frame_err=0, rx_done_tick=0, both synchronizer flops=1.
- Input synchronizer: `rx` passes through a 2-flop synchronizer to give `rx_s`. The FSM uses only `rx_s`.
- Counters and registers:
  - s_reg is 5 bits and counts s_ticks (0..31).
  - n_reg is 3 bits and counts data bits (0..DATA_BIT-1).
  - b_reg is an 8-bit shift register.
- FSM states: idle, start, data, stop.
  - idle: when rx_s==0, go to start and set s=0. This is evaluated every clk and does not wait for s_tick.
  - start: on each s_tick, if s==7:
    - rx_s==0: go to data, s=0, n=0 (now at mid-start-bit).
    - rx_s==1: glitch; return to idle, no output activity.
    - Otherwise s++.
  - data: on each s_tick, if s==15:
    - b = {rx_s, b[7:1]}, s=0.
    - If n==DATA_BIT-1, go to stop; else n++.
    - Otherwise s++.
  - stop: on each s_tick, if s==STOP_BIT*16-1:
    - Go to idle.
    - Register rx_data = b >> (8-DATA_BIT), so data is right-aligned and upper bits are 0.
    - Register frame_err = ~rx_s.
    - Register rx_done_tick=1 for exactly one clk.
    - Otherwise s++.
- Output timing:
  - rx_done_tick, rx_data and frame_err change together, one clk after the clock edge where the final stop s_tick is sampled.
  - rx_done_tick is low in every other cycle.
- Framing errors: rx_done_tick fires on a frame error too, with rx_data still loaded. frame_err stays at its value until the next rx_done_tick.
- Recovery and back-to-back frames: after stop the FSM is in idle, about half a bit before the stop-bit end. A following start edge is accepted immediately, so back-to-back frames need no idle gap. A LOW line after a frame error is treated as a new start.
- s_tick handling: s_tick is ignored in idle. In other states, counters advance only on s_tick.
- Reset mid-frame: returns to idle at once. No rx_done_tick is produced, and the outputs take their reset values.

Test Plan:
Common setup: s_tick every 4 clk, so one bit = 64 clk.
1. Assert reset_n=0 for 3 clk with rx=1 -> rx_data=0x00, frame_err=0, rx_done_tick=0; no pulse within 2000 clk after release.
2. Send 0xA5 in 8N1 -> exactly one rx_done_tick. rx_data=0xA5, frame_err=0, and rx_data holds 0xA5 afterwards.
3. Pull rx LOW for 4 s_ticks, then HIGH -> no rx_done_tick and FSM back in idle. A following 0x3C frame gives rx_data=0x3C, frame_err=0.
4. Send 0x5A with the stop bit driven LOW -> rx_done_tick with rx_data=0x5A, frame_err=1. Then hold rx HIGH for 20 bit-times and send 0xC3 -> rx_data=0xC3, frame_err=0.
5. Send 0x00 and 0xFF back-to-back with no gap -> two rx_done_ticks about 160 s_ticks apart. Data 0x00 then 0xFF, frame_err=0 both times.
6. Assert reset_n during data bit 3 of frame 0x81 -> no rx_done_tick and outputs reset. Then send 0x81 -> rx_data=0x81. Separately, with DATA_BIT=7, STOP_BIT=2, send 0x55 -> rx_data=0x55 (bit7=0), frame_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB first, no parity.
// Presents each received character on rx_data with a one-clk rx_done_tick
// and a framing-error flag that reflects the most recent stop-bit sample.
module uart_rx #(
  parameter int DATA_BIT = 8,  // data bits per frame, 5..8
  parameter int STOP_BIT = 1   // stop bits, 1 or 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Last data-bit index and last s_tick count of the stop interval.
  localparam logic [2:0] N_LAST      = 3'(DATA_BIT - 1);
  localparam logic [4:0] S_STOP_LAST = 5'(STOP_BIT * 16 - 1);
  // Bits are shifted in from the top, so a short frame ends up left-aligned.
  localparam int         ALIGN       = 8 - DATA_BIT;

  state_t     state;
  logic [4:0] s_reg;
  logic [2:0] n_reg;
  logic [7:0] b_reg;
  logic       rx_meta;
  logic       rx_s;

  // Two-flop synchronizer; resets to the idle-HIGH line level so reset
  // release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let both flops sample the old values,
      // giving a true two-stage pipeline rather than a single wire-through.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      rx_data      <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      // NOTE: default-low here makes rx_done_tick a single-clk pulse; only the
      // final stop tick overrides it below.
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Start edge is looked for every clk, independent of s_tick.
          if (!rx_s) begin
            state <= START;
            s_reg <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == 5'd7) begin
              if (!rx_s) begin
                // Mid start bit and still LOW: a real frame.
                state <= DATA;
                s_reg <= '0;
                n_reg <= '0;
              end else begin
                // Line went back HIGH: glitch, drop it silently.
                state <= IDLE;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == 5'd15) begin
              b_reg <= {rx_s, b_reg[7:1]};
              s_reg <= '0;
              if (n_reg == N_LAST) begin
                state <= STOP;
              end else begin
                n_reg <= n_reg + 3'd1;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_reg == S_STOP_LAST) begin
              // Back to idle mid stop bit so a back-to-back start is caught.
              state        <= IDLE;
              rx_data      <= b_reg >> ALIGN;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
